// File: rtl/tac_event_tagger.sv
// tac_event_tagger: synchronises raw PMT and sync pulses, measures the cycles
// elapsed since the latest sync edge for each photon, quantises that delay to
// a histogram bin, and queues the bins in a first-word fall-through FIFO that
// the histogram accumulator drains through a valid/ready handshake.
module tac_event_tagger #(
    parameter int NBINS      = 128,
    parameter int BIN_SHIFT  = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     en_in,
    input  logic                     clr_in,
    input  logic                     pmt_in,
    input  logic                     sync_in,
    input  logic                     ev_ready_in,
    output logic                     ev_valid_out,
    output logic [$clog2(NBINS)-1:0] ev_bin_out,
    output logic [31:0]              photon_cnt_out,
    output logic [31:0]              sync_cnt_out,
    output logic [15:0]              drop_cnt_out,
    output logic [15:0]              unsync_cnt_out,
    output logic                     pmt_out
);

    localparam int          BW  = $clog2(NBINS);
    localparam int          AW  = $clog2(FIFO_DEPTH);
    localparam logic [15:0] OVF = 16'(NBINS - 1);

    // Clamp the shifted delay into the bin range; anything past the last
    // regular bin lands in the overflow bin.
    function automatic logic [BW-1:0] to_bin(input logic [15:0] elapsed);
        logic [15:0] raw;
        raw = elapsed >> BIN_SHIFT;
        if (raw >= OVF) begin
            return BW'(NBINS - 1);
        end
        return raw[BW-1:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 0: synchroniser chains
    logic pmt_s1_q, pmt_s2_q, pmt_s3_q;
    logic sync_s1_q, sync_s2_q, sync_s3_q;

    // Stage 1: registered edge pulses
    logic pmt_edge_q, sync_edge_q;
    logic pmt_edge_d, sync_edge_d;

    // Stage 2: timing state, counters and FIFO
    logic        have_sync_q, have_sync_d;
    logic [15:0] elapsed_q, elapsed_d;
    logic [31:0] photon_cnt_q, photon_cnt_d;
    logic [31:0] sync_cnt_q, sync_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] unsync_cnt_q, unsync_cnt_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] mem_q [FIFO_DEPTH];

    logic          fifo_empty, fifo_full;
    logic          have_sync_now, want_push, push, pop;
    logic          drop_evt, unsync_evt;
    logic [BW-1:0] bin_d;

    assign pmt_edge_d  = pmt_s2_q & ~pmt_s3_q;
    assign sync_edge_d = sync_s2_q & ~sync_s3_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A sync edge in the same cycle as a photon arms tagging immediately.
    assign have_sync_now = have_sync_q | sync_edge_q;
    assign want_push     = en_in & pmt_edge_q & have_sync_now;
    assign pop           = ~fifo_empty & ev_ready_in;
    // A concurrent pop frees the slot, so a full FIFO can still accept.
    assign push          = want_push & (~fifo_full | pop);
    assign drop_evt      = want_push & fifo_full & ~pop;
    assign unsync_evt    = en_in & pmt_edge_q & ~have_sync_now;

    // The photon uses the elapsed value being loaded this cycle, so a
    // coincident sync edge gives 0 and the following cycle gives 1.
    assign bin_d = to_bin(elapsed_d);

    // Next-state for elapsed timer, sync flag, statistics and FIFO pointers.
    always_comb begin
        elapsed_d    = elapsed_q;
        have_sync_d  = have_sync_q;
        photon_cnt_d = photon_cnt_q;
        sync_cnt_d   = sync_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        unsync_cnt_d = unsync_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (sync_edge_q) begin
            elapsed_d   = 16'd0;
            have_sync_d = 1'b1;
        end else begin
            elapsed_d = sat_inc16(elapsed_q);
        end

        if (clr_in) begin
            photon_cnt_d = 32'd0;
            sync_cnt_d   = 32'd0;
            drop_cnt_d   = 16'd0;
            unsync_cnt_d = 16'd0;
        end else begin
            if (pmt_edge_q)  photon_cnt_d = photon_cnt_q + 32'd1;
            if (sync_edge_q) sync_cnt_d   = sync_cnt_q + 32'd1;
            if (drop_evt)    drop_cnt_d   = sat_inc16(drop_cnt_q);
            if (unsync_evt)  unsync_cnt_d = sat_inc16(unsync_cnt_q);
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pmt_s1_q     <= 1'b0;
            pmt_s2_q     <= 1'b0;
            pmt_s3_q     <= 1'b0;
            sync_s1_q    <= 1'b0;
            sync_s2_q    <= 1'b0;
            sync_s3_q    <= 1'b0;
            pmt_edge_q   <= 1'b0;
            sync_edge_q  <= 1'b0;
            have_sync_q  <= 1'b0;
            elapsed_q    <= 16'hFFFF;
            photon_cnt_q <= 32'd0;
            sync_cnt_q   <= 32'd0;
            drop_cnt_q   <= 16'd0;
            unsync_cnt_q <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            pmt_s1_q     <= pmt_in;
            pmt_s2_q     <= pmt_s1_q;
            pmt_s3_q     <= pmt_s2_q;
            sync_s1_q    <= sync_in;
            sync_s2_q    <= sync_s1_q;
            sync_s3_q    <= sync_s2_q;
            pmt_edge_q   <= pmt_edge_d;
            sync_edge_q  <= sync_edge_d;
            have_sync_q  <= have_sync_d;
            elapsed_q    <= elapsed_d;
            photon_cnt_q <= photon_cnt_d;
            sync_cnt_q   <= sync_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            unsync_cnt_q <= unsync_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bin_d;
        end
    end

    assign ev_valid_out   = ~fifo_empty;
    assign ev_bin_out     = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign photon_cnt_out = photon_cnt_q;
    assign sync_cnt_out   = sync_cnt_q;
    assign drop_cnt_out   = drop_cnt_q;
    assign unsync_cnt_out = unsync_cnt_q;
    assign pmt_out        = pmt_edge_q;

endmodule
